// File: rtl/shift_sequencer_if.sv
`default_nettype none
// ============================================================================
// shift_sequencer_if : request/response handshake bundle for shift_sequencer
// Revision 1.0
// ============================================================================
interface shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [AMT_W-1:0] req_amt;
    logic             req_dir;
    logic             req_fill;
    logic             req_arith;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ovf;

    modport master (
        output req_valid, req_data, req_amt, req_dir, req_fill, req_arith, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_ovf
    );

    modport slave (
        input  req_valid, req_data, req_amt, req_dir, req_fill, req_arith, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_ovf
    );
endinterface
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// shift_sequencer : multi-pass shift controller around two nBit_Shift units
// (optional abort input enabled by macro SHIFT_SEQ_ABORT_EN). Revision 1.0
// ============================================================================

// Shift field: bit 0 = direction (1 = right), bits WIDTH-2:1 = amount,
// bit WIDTH-1 = fill. OP=1 replicates the sign bit on right shifts.
module nBit_Shift #(
    parameter int WIDTH = 4,
    parameter int OP    = 0
) (
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_shift,
    output logic      [WIDTH-1:0] o_y,
    output logic      [WIDTH-1:0] o_ovf
);
    logic [WIDTH-3:0]   w_amt;
    logic               w_dir;
    logic               w_fill;
    logic               w_rfill;
    logic [2*WIDTH-1:0] w_left;
    logic [2*WIDTH-1:0] w_right;
    logic [WIDTH-1:0]   w_vac_left;
    logic [WIDTH-1:0]   w_vac_right;

    assign w_amt  = i_shift[WIDTH-2:1];
    assign w_dir  = i_shift[0];
    assign w_fill = i_shift[WIDTH-1];

    if (OP == 0) begin : g_logical
        assign w_rfill = w_fill;
    end else begin : g_arith
        assign w_rfill = i_a[WIDTH-1];
    end

    // Double-width shifts keep the discarded bits in the other half.
    assign w_left      = {{WIDTH{1'b0}}, i_a} << w_amt;
    assign w_right     = {i_a, {WIDTH{1'b0}}} >> w_amt;
    assign w_vac_left  = ~({WIDTH{1'b1}} << w_amt);
    assign w_vac_right = ~({WIDTH{1'b1}} >> w_amt);

    always_comb begin
        o_y   = w_left[WIDTH-1:0] | (w_vac_left & {WIDTH{w_fill}});
        o_ovf = w_left[2*WIDTH-1:WIDTH];
        if (w_dir) begin
            o_y   = w_right[2*WIDTH-1:WIDTH] | (w_vac_right & {WIDTH{w_rfill}});
            o_ovf = w_right[WIDTH-1:0];
        end
    end
endmodule

module shift_sequencer #(
    parameter int WIDTH    = 4,
    parameter int AMT_W    = 3,
    parameter int STEP_MAX = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
`ifdef SHIFT_SEQ_ABORT_EN
    input  wire logic         abort,
`endif
    shift_sequencer_if.slave  bus
);
    localparam int REM_W = $clog2(WIDTH + 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state_q, w_state_d;
    logic [WIDTH-1:0] r_acc_q,   w_acc_d;
    logic [REM_W-1:0] r_rem_q,   w_rem_d;
    logic             r_ovf_q,   w_ovf_d;
    logic             r_dir_q,   w_dir_d;
    logic             r_fill_q,  w_fill_d;
    logic             r_arith_q, w_arith_d;

    logic [REM_W-1:0] w_amt_clamp;
    logic [REM_W-1:0] w_step;
    logic [WIDTH-1:0] w_field;
    logic [WIDTH-1:0] w_log_y,   w_log_ovf;
    logic [WIDTH-1:0] w_ari_y,   w_ari_ovf;
    logic [WIDTH-1:0] w_pass_y,  w_pass_ovf;

    always_comb begin
        w_amt_clamp = REM_W'(WIDTH);
        if (32'(bus.req_amt) <= 32'(WIDTH)) begin
            w_amt_clamp = REM_W'(bus.req_amt);
        end
        w_step = r_rem_q;
        if (32'(r_rem_q) > 32'(STEP_MAX)) begin
            w_step = REM_W'(STEP_MAX);
        end
    end

    assign w_field = {r_fill_q, (WIDTH-2)'(w_step), r_dir_q};

    nBit_Shift #(.WIDTH(WIDTH), .OP(0)) u_shift_log (
        .i_a     (r_acc_q),
        .i_shift (w_field),
        .o_y     (w_log_y),
        .o_ovf   (w_log_ovf)
    );

    nBit_Shift #(.WIDTH(WIDTH), .OP(1)) u_shift_ari (
        .i_a     (r_acc_q),
        .i_shift (w_field),
        .o_y     (w_ari_y),
        .o_ovf   (w_ari_ovf)
    );

    assign w_pass_y   = r_arith_q ? w_ari_y   : w_log_y;
    assign w_pass_ovf = r_arith_q ? w_ari_ovf : w_log_ovf;

    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_rem_d   = r_rem_q;
        w_ovf_d   = r_ovf_q;
        w_dir_d   = r_dir_q;
        w_fill_d  = r_fill_q;
        w_arith_d = r_arith_q;
        case (r_state_q)
            c_IDLE: begin
                if (bus.req_valid) begin
                    w_acc_d   = bus.req_data;
                    w_dir_d   = bus.req_dir;
                    w_fill_d  = bus.req_fill;
                    w_arith_d = bus.req_arith;
                    w_rem_d   = w_amt_clamp;
                    w_ovf_d   = 1'b0;
                    w_state_d = (w_amt_clamp != '0) ? c_RUN : c_DONE;
                end
            end
            c_RUN: begin
                w_acc_d = w_pass_y;
                w_ovf_d = r_ovf_q | (|w_pass_ovf);
                w_rem_d = r_rem_q - w_step;
                if (r_rem_q == w_step) begin
                    w_state_d = c_DONE;
                end
            end
            c_DONE: begin
                if (bus.rsp_ready) begin
                    w_state_d = c_IDLE;
                end
            end
            default: w_state_d = c_IDLE;
        endcase
`ifdef SHIFT_SEQ_ABORT_EN
        // Abort wins over a completing response handshake.
        if (abort && (r_state_q != c_IDLE)) begin
            w_state_d = c_IDLE;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= c_IDLE;
            r_acc_q   <= '0;
            r_rem_q   <= '0;
            r_ovf_q   <= 1'b0;
            r_dir_q   <= 1'b0;
            r_fill_q  <= 1'b0;
            r_arith_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_acc_q   <= w_acc_d;
            r_rem_q   <= w_rem_d;
            r_ovf_q   <= w_ovf_d;
            r_dir_q   <= w_dir_d;
            r_fill_q  <= w_fill_d;
            r_arith_q <= w_arith_d;
        end
    end

    assign bus.req_ready = (r_state_q == c_IDLE);
    assign bus.rsp_valid = (r_state_q == c_DONE);
    assign bus.rsp_data  = r_acc_q;
    assign bus.rsp_ovf   = r_ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// tb_shift_sequencer : directed self-checking bench for shift_sequencer
// Revision 1.0
// ============================================================================
module tb_shift_sequencer;
    localparam int c_WIDTH = 4;
    localparam int c_AMT_W = 3;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    shift_sequencer_if #(.WIDTH(c_WIDTH), .AMT_W(c_AMT_W)) bus ();

`ifdef SHIFT_SEQ_ABORT_EN
    logic abort;
`endif

    shift_sequencer #(.WIDTH(c_WIDTH), .AMT_W(c_AMT_W), .STEP_MAX(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge; presents a request and returns #1 after the accept edge.
    task automatic send_req(input logic [3:0] data, input logic [2:0] amt,
                            input logic dir, input logic fill, input logic arith);
        bus.req_data  = data;
        bus.req_amt   = amt;
        bus.req_dir   = dir;
        bus.req_fill  = fill;
        bus.req_arith = arith;
        bus.req_valid = 1'b1;
        check("req_ready_pre", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int exp_lat,
                            input logic [3:0] exp_data, input logic exp_ovf);
        int lat;
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_data));
        check({tag, "_ovf"}, 32'(bus.rsp_ovf), 32'(exp_ovf));
        check({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic seen;
        n_total = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
`ifdef SHIFT_SEQ_ABORT_EN
        abort   = 1'b0;
`endif
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.req_amt   = '0;
        bus.req_dir   = 1'b0;
        bus.req_fill  = 1'b0;
        bus.req_arith = 1'b0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_rsp_ovf", 32'(bus.rsp_ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_req(4'b1011, 3'd2, 1'b0, 1'b0, 1'b0);
        wait_rsp("lsl2", 2, 4'b1100, 1'b1);

        send_req(4'b1000, 3'd3, 1'b1, 1'b0, 1'b1);
        wait_rsp("asr3", 3, 4'b1111, 1'b0);

        send_req(4'b0110, 3'd0, 1'b0, 1'b0, 1'b0);
        wait_rsp("amt0", 0, 4'b0110, 1'b0);

        send_req(4'b0101, 3'd7, 1'b1, 1'b1, 1'b0);
        wait_rsp("clamp", 4, 4'b1111, 1'b1);

        send_req(4'b0110, 3'd1, 1'b1, 1'b1, 1'b1);
        wait_rsp("asr1_pos", 1, 4'b0011, 1'b0);

        send_req(4'b0001, 3'd1, 1'b0, 1'b1, 1'b0);
        wait_rsp("lsl_fill1", 1, 4'b0011, 1'b0);

        // Reset while the second of four passes is pending.
        send_req(4'b1111, 3'd4, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("midrun_req_ready", 32'(bus.req_ready), 32'd1);
        check("midrun_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrun_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("midrun_rsp_ovf", 32'(bus.rsp_ovf), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("midrun_no_rsp", 32'(seen), 32'd0);

        // Backpressure with a different request waiting.
        send_req(4'b0011, 3'd1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("bp_valid", 32'(bus.rsp_valid), 32'd1);
        bus.req_data  = 4'b1001;
        bus.req_amt   = 3'd1;
        bus.req_dir   = 1'b1;
        bus.req_fill  = 1'b0;
        bus.req_arith = 1'b0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_hold_data", 32'(bus.rsp_data), 32'b0110);
            check("bp_hold_ovf", 32'(bus.rsp_ovf), 32'd0);
            check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
            check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("bp_hs_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp_hs_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("bp_accept", 32'(bus.req_ready), 32'd0);
        wait_rsp("bp_next", 1, 4'b0100, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire
